// File: rtl/down_counter_arbiter.sv
// Two-requester arbiter sharing one 3-bit down counter. The winner's len is
// loaded at grant, the counter runs down to 0, then a one-cycle done pulse
// marks completion. Dropping the request mid-count aborts without done.
module down_counter_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [2:0] len0,
  input  logic       req1,
  input  logic [2:0] len1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [2:0] cnt,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t     state, state_nx;
  logic       owner, owner_nx;   // requester currently holding the counter
  logic       ptr, ptr_nx;       // requester favoured on contention
  logic [2:0] cnt_nx;
  logic       gnt0_nx, gnt1_nx, done0_nx, done1_nx, busy_nx;
  logic       win, owner_req;

  // State and all outputs are registered from the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr   <= 1'b0;
      cnt   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      gnt0  <= gnt0_nx;
      gnt1  <= gnt1_nx;
      done0 <= done0_nx;
      done1 <= done1_nx;
      busy  <= busy_nx;
    end
  end

  // Next state, arbitration and next output values.
  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    ptr_nx    = ptr;
    cnt_nx    = cnt;
    gnt0_nx   = 1'b0;
    gnt1_nx   = 1'b0;
    done0_nx  = 1'b0;
    done1_nx  = 1'b0;
    win       = 1'b0;
    owner_req = owner ? req1 : req0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1)
            win = (RR_EN != 0) ? ptr : 1'b0;
          else
            win = ~req0;
          owner_nx = win;
          cnt_nx   = win ? len1 : len0;
          gnt0_nx  = ~win;
          gnt1_nx  = win;
          state_nx = COUNT;
        end
      end
      COUNT: begin
        if (!owner_req) begin
          state_nx = IDLE;
        end else if (cnt == 3'd0) begin
          done0_nx = ~owner;
          done1_nx = owner;
          ptr_nx   = ~owner;
          state_nx = DONE;
        end else begin
          cnt_nx  = cnt - 3'd1;
          gnt0_nx = ~owner;
          gnt1_nx = owner;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule
